// File: rtl/nx_ram_1r1w_arb.sv
// nx_ram_1r1w_arb: two-client read/write access controller for one
// nx_ram_1r1w instance, with optional post-reset init sweep.
//
// Ports:
//   clk, rst          sole clock, synchronous active-high reset
//   init_done         high once the controller grants clients (RUN)
//   c{0,1}_rd_*       read request/address/grant/return-valid
//   rd_data           read return data shared by both clients
//   c{0,1}_wr_*       write request/address/data/grant
//   ram_*             RAM drive (active-low enables), ram_dout return
//
// Build option: define NX_RAM_ARB_INIT_EN to enable the INIT sweep that
// writes INIT_VALUE to every entry before any client is granted.
module nx_ram_1r1w_arb #(
    parameter int unsigned      WIDTH      = 64,
    parameter int unsigned      DEPTH      = 256,
    parameter int unsigned      RD_LATENCY = 1,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0,
    localparam int unsigned     AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             init_done,
    input  logic             c0_rd_req,
    input  logic [AW-1:0]    c0_rd_addr,
    output logic             c0_rd_gnt,
    output logic             c0_rd_vld,
    input  logic             c1_rd_req,
    input  logic [AW-1:0]    c1_rd_addr,
    output logic             c1_rd_gnt,
    output logic             c1_rd_vld,
    output logic [WIDTH-1:0] rd_data,
    input  logic             c0_wr_req,
    input  logic [AW-1:0]    c0_wr_addr,
    input  logic [WIDTH-1:0] c0_wr_data,
    output logic             c0_wr_gnt,
    input  logic             c1_wr_req,
    input  logic [AW-1:0]    c1_wr_addr,
    input  logic [WIDTH-1:0] c1_wr_data,
    output logic             c1_wr_gnt,
    output logic             ram_reb,
    output logic             ram_web,
    output logic [AW-1:0]    ram_ra,
    output logic [AW-1:0]    ram_wa,
    output logic [WIDTH-1:0] ram_din,
    output logic [WIDTH-1:0] ram_bwe,
    input  logic [WIDTH-1:0] ram_dout
);

    logic run;
    logic init_act;

`ifdef NX_RAM_ARB_INIT_EN
    typedef enum logic {
        S_INIT,
        S_RUN
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] ia_q, ia_d;
    logic          init_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            ia_q    <= '0;
        end else begin
            state_q <= state_d;
            ia_q    <= ia_d;
        end
    end

    // The counter stops on the last address instead of wrapping.
    always_comb begin
        state_d = state_q;
        ia_d    = ia_q;
        init_wr = 1'b0;
        unique case (state_q)
            S_INIT: begin
                init_wr = 1'b1;
                if (ia_q == AW'(DEPTH - 1)) begin
                    state_d = S_RUN;
                end else begin
                    ia_d = ia_q + 1'b1;
                end
            end
            S_RUN:   state_d = S_RUN;
            default: state_d = S_INIT;
        endcase
    end

    // Nothing is driven while reset is held, whatever the old state.
    assign run      = (state_q == S_RUN) && !rst;
    assign init_act = init_wr && !rst;
`else
    logic unused_init;

    assign unused_init = ^INIT_VALUE;
    assign run         = !rst;
    assign init_act    = 1'b0;
`endif

    assign init_done = run;

    // Round-robin arbiters: pointer names the favoured client.
    logic       rp_q, rp_d;
    logic       wp_q, wp_d;
    logic [1:0] rd_gnt;
    logic [1:0] wr_gnt;

    always_comb begin
        rd_gnt = 2'b00;
        wr_gnt = 2'b00;
        if (run) begin
            unique case ({c1_rd_req, c0_rd_req})
                2'b01:   rd_gnt = 2'b01;
                2'b10:   rd_gnt = 2'b10;
                2'b11:   rd_gnt = rp_q ? 2'b10 : 2'b01;
                default: rd_gnt = 2'b00;
            endcase
            unique case ({c1_wr_req, c0_wr_req})
                2'b01:   wr_gnt = 2'b01;
                2'b10:   wr_gnt = 2'b10;
                2'b11:   wr_gnt = wp_q ? 2'b10 : 2'b01;
                default: wr_gnt = 2'b00;
            endcase
        end
    end

    always_comb begin
        rp_d = rp_q;
        wp_d = wp_q;
        if (rd_gnt[0]) rp_d = 1'b1;
        if (rd_gnt[1]) rp_d = 1'b0;
        if (wr_gnt[0]) wp_d = 1'b1;
        if (wr_gnt[1]) wp_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rp_q <= 1'b0;
            wp_q <= 1'b0;
        end else begin
            rp_q <= rp_d;
            wp_q <= wp_d;
        end
    end

    assign c0_rd_gnt = rd_gnt[0];
    assign c1_rd_gnt = rd_gnt[1];
    assign c0_wr_gnt = wr_gnt[0];
    assign c1_wr_gnt = wr_gnt[1];

    // RAM drive; idle ports park at disabled with zero address/data.
    always_comb begin
        ram_reb = 1'b1;
        ram_ra  = '0;
        ram_web = 1'b1;
        ram_wa  = '0;
        ram_din = '0;
        if (rd_gnt[0]) begin
            ram_reb = 1'b0;
            ram_ra  = c0_rd_addr;
        end else if (rd_gnt[1]) begin
            ram_reb = 1'b0;
            ram_ra  = c1_rd_addr;
        end
        if (init_act) begin
            ram_web = 1'b0;
`ifdef NX_RAM_ARB_INIT_EN
            ram_wa  = ia_q;
`endif
            ram_din = INIT_VALUE;
        end else if (wr_gnt[0]) begin
            ram_web = 1'b0;
            ram_wa  = c0_wr_addr;
            ram_din = c0_wr_data;
        end else if (wr_gnt[1]) begin
            ram_web = 1'b0;
            ram_wa  = c1_wr_addr;
            ram_din = c1_wr_data;
        end
    end

    assign ram_bwe = '1;

    // Return tracking: {valid, client id} follows the RAM read latency.
    logic [RD_LATENCY-1:0] vld_q;
    logic [RD_LATENCY-1:0] id_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            id_q  <= '0;
        end else begin
            vld_q[0] <= |rd_gnt;
            id_q[0]  <= rd_gnt[1];
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                vld_q[i] <= vld_q[i-1];
                id_q[i]  <= id_q[i-1];
            end
        end
    end

    assign c0_rd_vld = vld_q[RD_LATENCY-1] & ~id_q[RD_LATENCY-1];
    assign c1_rd_vld = vld_q[RD_LATENCY-1] &  id_q[RD_LATENCY-1];
    assign rd_data   = ram_dout;

endmodule

// File: doc/nx_ram_1r1w_arb.md
# nx_ram_1r1w_arb

Two-client access controller for one `nx_ram_1r1w` instance. Arbitrates round-robin between two read clients and, independently, between two write clients, so one read and one write can issue in the same cycle. Tracks in-flight reads through the RAM's fixed read latency and returns each result tagged to its issuing client. After reset it can sweep the whole array to a known value before granting any client.

## Interface
- `WIDTH`, 64, data width; must match the RAM.
- `DEPTH`, 256, RAM entries; any value ≥2, power of two not required.
- `RD_LATENCY`, 1, cycles from an accepted read to RAM data valid; equals RAM `RD_LATENCY + OUT_FLOP`.
- `INIT_VALUE`, 0, `WIDTH`-bit word written to every entry during the init sweep.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `init_done`  out  1  high once the controller is in RUN.
- `c{0,1}_rd_req`  in  1  read request.
- `c{0,1}_rd_addr`  in  log2(DEPTH)  read address.
- `c{0,1}_rd_gnt`  out  1  read accepted this cycle.
- `c{0,1}_rd_vld`  out  1  `rd_data` belongs to this client.
- `rd_data`  out  WIDTH  read return data, shared by both clients.
- `c{0,1}_wr_req`  in  1  write request.
- `c{0,1}_wr_addr`  in  log2(DEPTH)  write address.
- `c{0,1}_wr_data`  in  WIDTH  write data.
- `c{0,1}_wr_gnt`  out  1  write accepted this cycle.
- `ram_reb`, `ram_web`  out  1  RAM read and write enables, active-low.
- `ram_ra`, `ram_wa`  out  log2(DEPTH)  RAM read and write addresses.
- `ram_din`  out  WIDTH  RAM write data.
- `ram_bwe`  out  WIDTH  RAM bit-write enables; tied to all ones.
- `ram_dout`  in  WIDTH  RAM read data.

## Operation
- FSM states: INIT and RUN. Reset enters INIT.
- INIT behaviour:
  - Counter `ia` runs from 0 to DEPTH-1, one write per cycle: `ram_web=0`, `ram_wa=ia`, `ram_din=INIT_VALUE`.
  - All grants are 0 and `ram_reb=1`.
  - After writing address DEPTH-1 the FSM moves to RUN. The counter saturates there and never wraps.
- RUN, read arbiter:
  - A one-bit pointer `rp` marks the favoured client.
  - Only one client requesting: that client is granted.
  - Both requesting: client `rp` is granted.
  - After any grant to client k, `rp` becomes `~k`. With no grant, `rp` holds.
- RUN, write arbiter: identical scheme with its own pointer `wp`, independent of the read side.
- A grant is combinational from the request in the same cycle. A transfer happens on `req & gnt`.
- A client may deassert a request without being granted; no grant is owed to it.
- RAM drive on an accepted read: `ram_reb=0`, `ram_ra` = the winner's address.
- RAM drive on an accepted write: `ram_web=0`, `ram_wa` and `ram_din` = the winner's address and data.
- Idle ports drive their enable at 1 and their address/data at 0.
- Return tracking:
  - A shift register of depth `RD_LATENCY` carries {valid, client id}.
  - Stage 0 loads on each accepted read.
  - At the last stage, `c<id>_rd_vld=1` and `rd_data=ram_dout`.
- Read and write to the same address in one cycle: the read returns the old contents. The controller adds no bypass.

## Timing
- Reset values: `init_done=0`, all `gnt` and `rd_vld` = 0, `ram_reb=1`, `ram_web=1`, `rp=wp=0`, tracking pipeline cleared.
- First INIT write happens in the first cycle after `rst` deasserts.
- INIT lasts exactly DEPTH cycles. `init_done` rises in cycle DEPTH, and the first grant can occur in that same cycle.
- Read latency: a read granted in cycle t produces `rd_vld` in cycle t+RD_LATENCY.
- Throughput: one read plus one write per cycle, sustained.
- `rst` asserted mid-operation:
  - In-flight reads are discarded and `rd_vld` is 0 the next cycle.
  - INIT restarts from address 0.
  - Pointers return to 0.

## Configuration
- Macro: `NX_RAM_ARB_INIT_EN`.
- Defined: the INIT sweep runs as described above.
- Undefined:
  - No INIT state and no `ia` counter.
  - The FSM enters RUN directly: `init_done=1` and grants are possible in the first cycle after reset.
  - `INIT_VALUE` is unused.
  - RAM contents are undefined until each entry is written.

## Test plan
- Init sweep: DEPTH=8, INIT_VALUE=0xA5, macro defined → `ram_web=0` for 8 cycles at addresses 0–7, `init_done` high in cycle 8, then reads of all 8 addresses return 0xA5.
- Round-robin fairness: both clients hold `rd_req` for 6 cycles → grants go c0,c1,c0,c1,c0,c1 and each `rd_vld` follows its grant by exactly RD_LATENCY (test with 1 and 3).
- Concurrent access: c0 writes 0x1234 to address 5 while c1 reads address 5 in the same cycle → c1 gets the old value. A read of address 5 one cycle later returns 0x1234.
- Pointer hold: c1 granted alone, then an idle gap, then both clients request → c0 granted first.
- Reset mid-flight: RD_LATENCY=3, `rst` asserted one cycle after a read grant → no `rd_vld` appears and the INIT sweep restarts at address 0.
- Macro undefined → `init_done=1` and a `c0_rd_req` is granted in the first cycle after reset.
